// File: rtl/scan_chain_host_if.sv
// scan_chain_host_if
// Byte streams between the host bridge (UART/SPI) and scan_chain_host.
//   tx_data  [7:0] chain-image byte toward the block, MSB shifted first
//   tx_valid       tx_data valid
//   tx_ready       block accepts tx_data this cycle
//   rx_data  [7:0] readback byte, first-captured bit in MSB
//   rx_valid       rx_data valid
//   rx_ready       consumer accepts rx_data
// master = host bridge side, slave = scan_chain_host side.
interface scan_chain_host_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/scan_chain_host.sv
// scan_chain_host
// Host-side driver for the microcontroller scan chain. Streams a chain image
// in byte by byte, shifts it out on scan_in while capturing scan_out
// (full duplex), and returns the captured bytes on a second stream.
// Optionally releases proc_en after the load and waits for halt.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   start        one-cycle pulse in IDLE starts a transaction
//   run_after    sampled with start; enter RUN after the shift
//   bus          scan_chain_host_if.slave (tx / rx byte streams)
//   scan_enable  scan_in  scan_out   microcontroller scan chain
//   proc_en      halt                microcontroller run control
//   busy         high in any state except IDLE
//   done         one-cycle pulse on return to IDLE
//   timeout      sticky RUN timeout flag
//
// Build option: define SCAN_HALT_TIMEOUT_EN to bound RUN to TIMEOUT cycles;
// without it RUN waits for halt indefinitely and timeout is tied low.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start
// FETCH   | tx_ready high, waiting for next image byte
// SHIFT   | scan_enable high, one chain bit per cycle (n <= 8 cycles)
// DELIVER | rx_valid high, waiting for consumer to take readback byte
// RUN     | proc_en high, waiting for halt (or timeout)
module scan_chain_host #(
  parameter int CHAIN_LEN = 300,
  parameter int TIMEOUT   = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run_after,
  scan_chain_host_if.slave bus,
  output logic             scan_enable,
  output logic             scan_in,
  input  logic             scan_out,
  output logic             proc_en,
  input  logic             halt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);
  localparam int RW = $clog2(CHAIN_LEN + 1);

  if (CHAIN_LEN < 1) begin : g_chain_len_check
    $error("scan_chain_host: CHAIN_LEN must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("scan_chain_host: TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_DELIVER, S_RUN} state_t;
  state_t state, state_nx;

  logic [RW-1:0] remaining;
  logic [3:0]    bit_cnt;
  logic [3:0]    n_bits;
  logic [7:0]    tx_buf;
  logic [7:0]    rx_buf;
  logic          run_lat;
  logic          done_q;
  logic [31:0]   rem_ext;
  logic [3:0]    n_load;
  logic          shift_last;
  logic          run_expire;

  assign rem_ext    = 32'(remaining);
  assign n_load     = (rem_ext >= 32'd8) ? 4'd8 : rem_ext[3:0];
  assign shift_last = (bit_cnt == n_bits - 4'd1);

`ifdef SCAN_HALT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] run_cnt;
  logic          timeout_q;

  // A halt in the expiring cycle wins: it is a normal stop, not a timeout.
  assign run_expire = (state == S_RUN) && !halt && (run_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != S_RUN) run_cnt <= '0;
      else                run_cnt <= run_cnt + TW'(1);
      if (run_expire) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign run_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_FETCH;
      S_FETCH:   if (bus.tx_valid) state_nx = S_SHIFT;
      S_SHIFT:   if (shift_last) state_nx = S_DELIVER;
      S_DELIVER: if (bus.rx_ready) begin
        if (remaining != '0) state_nx = S_FETCH;
        else if (run_lat)    state_nx = S_RUN;
        else                 state_nx = S_IDLE;
      end
      S_RUN:     if (halt || run_expire) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining <= '0;
      bit_cnt   <= '0;
      n_bits    <= '0;
      tx_buf    <= '0;
      rx_buf    <= '0;
      run_lat   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state != S_IDLE) && (state_nx == S_IDLE);
      case (state)
        S_IDLE: if (start) begin
          run_lat   <= run_after;
          remaining <= RW'(CHAIN_LEN);
        end
        S_FETCH: if (bus.tx_valid) begin
          tx_buf  <= bus.tx_data;
          rx_buf  <= '0;  // unused low bits of a partial byte read as 0
          n_bits  <= n_load;
          bit_cnt <= '0;
        end
        S_SHIFT: begin
          tx_buf                <= {tx_buf[6:0], 1'b0};
          rx_buf[~bit_cnt[2:0]] <= scan_out;  // bit k lands at position 7-k
          remaining             <= remaining - RW'(1);
          bit_cnt               <= bit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    scan_enable  = 1'b0;
    scan_in      = 1'b0;
    proc_en      = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_FETCH:   bus.tx_ready = 1'b1;
      S_SHIFT: begin
        scan_enable = 1'b1;
        scan_in     = tx_buf[7];
      end
      S_DELIVER: bus.rx_valid = 1'b1;
      S_RUN:     proc_en = 1'b1;
      default: ;
    endcase
  end

  assign bus.rx_data = rx_buf;
  assign done        = done_q;
endmodule

// File: doc/scan_chain_host.md
Name: scan_chain_host

Overview:
- Host-side driver for the accumulator microcontroller's serial scan chain.
- Loads a chain image byte-by-byte over a valid/ready stream and drives scan_enable/scan_in.
- Captures scan_out simultaneously (full-duplex) and returns readback bytes over a second valid/ready stream.
- Optionally releases proc_en after loading and waits for halt. Sits between a host interface (UART/SPI bridge) and the microcontroller top.

Parameters:
- CHAIN_LEN, 300: total scan chain length in bits; must be ≥1.
- TIMEOUT, 65535: max RUN cycles before forced stop; used only with SCAN_HALT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse in IDLE begins a scan transaction; ignored otherwise
- run_after  input  1  sampled with start; 1 = enter RUN after the shift completes
- tx_data  input  8  next chain-image byte, MSB shifted first
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  block accepts tx_data this cycle
- rx_data  output  8  captured readback byte, first-captured bit in MSB
- rx_valid  output  1  rx_data valid
- rx_ready  input  1  consumer accepts rx_data
- scan_enable  output  1  to microcontroller scan_enable
- scan_in  output  1  to microcontroller scan_in
- scan_out  input  1  from microcontroller scan_out
- proc_en  output  1  to microcontroller proc_en
- halt  input  1  from microcontroller halt
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse on return to IDLE
- timeout  output  1  sticky error flag (SCAN_HALT_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. All outputs 0: tx_ready, rx_valid, rx_data, scan_enable, scan_in, proc_en, busy, done, timeout. Bit counter cleared. Reset mid-transaction aborts immediately with no partial rx byte delivered.
- States: IDLE, FETCH, SHIFT, DELIVER, RUN.
- IDLE → FETCH on start. Latch run_after. Load remaining = CHAIN_LEN.
- FETCH: tx_ready=1, scan_enable=0. On tx_valid&&tx_ready, latch the byte into the shift buffer, set n = min(8, remaining), go to SHIFT.
- SHIFT: scan_enable=1 for exactly n consecutive cycles.
  - scan_in = buffer MSB; buffer shifts left each cycle.
  - scan_out is sampled on each of those edges into the rx buffer, MSB-first.
  - remaining decrements by 1 per cycle.
  - After n cycles go to DELIVER.
  - Partial final byte (n<8): only tx_data[7:8-n] are used; rx_data[7:8-n] hold captures and the low bits are 0.
- DELIVER: scan_enable=0, rx_valid=1, rx_data stable until rx_valid&&rx_ready.
  - Then go to FETCH if remaining>0.
  - Otherwise go to RUN if run_after latched, else to IDLE with a done pulse.
- Byte count per transaction is ceil(CHAIN_LEN/8) in each direction. CHAIN_LEN=8k gives no partial byte.
- Chain contents are frozen whenever scan_enable=0; stalls on tx_valid or rx_ready never shift extra bits.
- RUN: proc_en=1, scan_enable=0. When halt=1 is sampled, deassert proc_en the next cycle, go to IDLE, pulse done.
- proc_en is never 1 while scan_enable=1.
- start while busy is ignored. tx_valid is ignored outside FETCH. rx_ready is ignored outside DELIVER.
- Counters: remaining is $clog2(CHAIN_LEN+1) bits. Bit-in-byte counter is 4 bits. No wrap-around.

Optional Feature:
- Macro: SCAN_HALT_TIMEOUT_EN.
- Defined: a RUN cycle counter ($clog2(TIMEOUT+1) bits) clears on RUN entry.
  - If TIMEOUT cycles elapse without halt, proc_en drops, timeout sets (sticky until reset), state → IDLE with done pulse.
  - halt and the timeout expiring in the same cycle count as a normal halt; timeout stays 0.
- Not defined: RUN waits indefinitely for halt. timeout is constant 0 and no counter is built.

Test Plan:
- CHAIN_LEN=12, tx bytes 0xA5, 0x30, scan_out looped from a 12-bit model chain preloaded 0xF0F → scan_in sequence 1,0,1,0,0,1,0,1,0,0,1,1. rx bytes 0xF0, 0xF0 (second byte = captured bits 1111 followed by zero fill). scan_enable high for exactly 12 cycles total. done pulse; proc_en stays 0.
- Same transaction with tx_valid held low 5 cycles before byte 2 and rx_ready held low 3 cycles on byte 1 → scan_enable low during all stalls; model chain state unchanged across stalls; identical rx bytes.
- CHAIN_LEN=16, run_after=1, halt asserted 20 cycles after RUN entry → proc_en rises after the second DELIVER handshake and falls one cycle after halt is sampled. done pulses once.
- rst=0 asserted during the 3rd SHIFT cycle → next cycle all outputs 0, state IDLE. A fresh start then completes normally.
- start pulsed while busy → ignored; byte counts unchanged.
- With SCAN_HALT_TIMEOUT_EN, TIMEOUT=10, halt never asserted → proc_en high exactly 10 cycles, then timeout=1 and done pulses. Without the macro, proc_en stays high for more than 1000 cycles.
